// File: rtl/sopc_base_leds_ext.sv
// Avalon-MM LED output PIO: atomic set/clear, per-bit blink, optional global PWM dimming.
// Define SOPC_LEDS_PWM_EN to build the PWM counter and DUTY register (address 5).
module sopc_base_leds_ext #(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       BLINK_CNT_W = 24,
  parameter int unsigned       PWM_BITS    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrSet    = 3'd1;
  localparam logic [2:0] AddrClear  = 3'd2;
  localparam logic [2:0] AddrMask   = 3'd3;
  localparam logic [2:0] AddrPeriod = 3'd4;
  localparam logic [2:0] AddrDuty   = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd6;

  localparam logic [BLINK_CNT_W-1:0] CntOne = BLINK_CNT_W'(1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (BLINK_CNT_W < 1 || BLINK_CNT_W > 32) begin : g_bad_blink_w
    $error("BLINK_CNT_W must be in 1..32");
  end
  if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_bad_pwm_bits
    $error("PWM_BITS must be in 2..16");
  end

  logic                   wr_en;
  logic                   period_wr;
  logic [WIDTH-1:0]       wr_bits;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [BLINK_CNT_W-1:0] period_q, period_d;
  logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   pwm_on;
  logic [31:0]            duty_rd;
  logic                   unused_writedata;

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en && (address == AddrPeriod);
  assign wr_bits   = writedata[WIDTH-1:0];
  // Upper writedata bits are ignored when registers are narrower than the bus.
  assign unused_writedata = ^writedata;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        AddrData:   data_d   = wr_bits;
        AddrSet:    data_d   = data_q | wr_bits;
        AddrClear:  data_d   = data_q & ~wr_bits;
        AddrMask:   mask_d   = wr_bits;
        AddrPeriod: period_d = writedata[BLINK_CNT_W-1:0];
        default:    ;
      endcase
    end
  end

  // A period write restarts the blink cycle and wins over a concurrent wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr || (period_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - CntOne) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

`ifdef SOPC_LEDS_PWM_EN
  localparam logic [PWM_BITS-1:0] PwmOne = PWM_BITS'(1);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_comb begin
    duty_d = duty_q;
    if (wr_en && (address == AddrDuty)) begin
      duty_d = writedata[PWM_BITS-1:0];
    end
  end

  // All-ones duty means fully on, otherwise on while the counter is below duty.
  assign pwm_on = (pwm_cnt_q < duty_q) | (duty_q == '1);

  always_comb begin
    duty_rd                 = '0;
    duty_rd[PWM_BITS-1:0]   = duty_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= '1;
      pwm_cnt_q <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + PwmOne;
    end
  end
`else
  assign pwm_on  = 1'b1;
  assign duty_rd = '0;
`endif

  assign out_d = data_q & (~mask_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_q    <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      AddrData, AddrSet, AddrClear: readdata[WIDTH-1:0]       = data_q;
      AddrMask:                     readdata[WIDTH-1:0]       = mask_q;
      AddrPeriod:                   readdata[BLINK_CNT_W-1:0] = period_q;
      AddrDuty:                     readdata                  = duty_rd;
      AddrStatus:                   readdata[0]               = phase_q;
      default:                      readdata                  = '0;
    endcase
  end

endmodule

// File: tb/tb_sopc_base_leds_ext.sv
// Self-checking bench for sopc_base_leds_ext: directed scenarios plus random bus traffic
// compared each cycle against a cycle-count based behavioural model.
module tb_sopc_base_leds_ext;

  localparam int unsigned      Width      = 8;
  localparam logic [Width-1:0] ResetValue = 8'h00;
  localparam int unsigned      BlinkCntW  = 24;
  localparam int unsigned      PwmBits    = 8;
  localparam int unsigned      DutyMax    = (1 << PwmBits) - 1;
  localparam logic [31:0]      PeriodMask = 32'((64'd1 << BlinkCntW) - 64'd1);

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [Width-1:0] out_port;

  always #5 clk = ~clk;

  sopc_base_leds_ext #(
    .WIDTH       (Width),
    .RESET_VALUE (ResetValue),
    .BLINK_CNT_W (BlinkCntW),
    .PWM_BITS    (PwmBits)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: register contents plus elapsed-cycle counts instead of hardware counters.
  logic [Width-1:0] m_data, m_mask, m_out;
  int unsigned      m_period, m_duty;
  int unsigned      m_t;    // cycles since last period write or reset
  int unsigned      m_pwm;  // cycles since reset

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_phase();
    if (m_period == 0) return 1'b1;
    return ((m_t / m_period) % 2) == 0;
  endfunction

  function automatic logic model_pwm_on();
`ifdef SOPC_LEDS_PWM_EN
    return (m_duty == DutyMax) || ((m_pwm % (1 << PwmBits)) < m_duty);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return 32'(m_data);
      3'd3:             return 32'(m_mask);
      3'd4:             return m_period;
`ifdef SOPC_LEDS_PWM_EN
      3'd5:             return m_duty;
`endif
      3'd6:             return {31'd0, model_phase()};
      default:          return 32'd0;
    endcase
  endfunction

  // Apply one bus cycle, advance DUT and model by one edge, compare outputs.
  task automatic cycle(input logic r, input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd);
    logic [Width-1:0] nxt;
    logic [Width-1:0] wb;
    reset      = r;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    wb  = wd[Width-1:0];
    nxt = m_data & (~m_mask | {Width{model_phase()}}) & {Width{model_pwm_on()}};
    @(posedge clk);
    #1;
    if (r) begin
      m_data   = ResetValue;
      m_mask   = '0;
      m_period = 0;
      m_duty   = DutyMax;
      m_t      = 0;
      m_pwm    = 0;
      m_out    = ResetValue;
    end else begin
      m_out = nxt;
      m_t++;
      m_pwm++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wb;
          3'd1: m_data = m_data | wb;
          3'd2: m_data = m_data & ~wb;
          3'd3: m_mask = wb;
          3'd4: begin
            m_period = wd & PeriodMask;
            m_t      = 0;
          end
`ifdef SOPC_LEDS_PWM_EN
          3'd5: m_duty = wd % (1 << PwmBits);
`endif
          default: ;
        endcase
      end
    end
    check_eq("out_port", 32'(out_port), 32'(m_out));
    check_eq($sformatf("readdata_a%0d", a), readdata, model_read(a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, a, $urandom());
  endtask

  initial begin
    int cnt;
    logic r, cs, wn;
    logic [2:0] a;
    logic [31:0] wd;

    m_data = '0; m_mask = '0; m_out = '0;
    m_period = 0; m_duty = DutyMax; m_t = 0; m_pwm = 0;

    // Reset values
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    check_eq("rst_out_port", 32'(out_port), 32'h0);
    idle(3'd0, 1);
    check_eq("rst_data", readdata, 32'h0);
    idle(3'd4, 1);
    check_eq("rst_period", readdata, 32'h0);
    idle(3'd6, 1);
    check_eq("rst_status", readdata, 32'h1);
    idle(3'd5, 1);
`ifdef SOPC_LEDS_PWM_EN
    check_eq("rst_duty", readdata, 32'hFF);
`else
    check_eq("rst_duty_absent", readdata, 32'h0);
`endif

    // Data, set, clear
    wr(3'd0, 32'hA5);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'h81);
    idle(3'd0, 1);
    check_eq("setclr_data", readdata, 32'h2E);
    check_eq("setclr_out", 32'(out_port), 32'h2E);

    // Blink with period 4
    wr(3'd0, 32'hFF);
    wr(3'd3, 32'h0F);
    wr(3'd4, 32'd4);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      idle(3'd6, 1);
      if (out_port == 8'hF0) cnt++;
    end
    check_eq("blink_low_cycles", cnt, 8);
    wr(3'd4, 32'd0);
    idle(3'd6, 6);
    check_eq("blink_off_out", 32'(out_port), 32'hFF);

    // Period rewrite in the low phase restarts high
    wr(3'd4, 32'd4);
    idle(3'd6, 6);
    check_eq("low_phase_status", readdata, 32'h0);
    wr(3'd4, 32'd4);
    idle(3'd6, 1);
    check_eq("rewrite_status", readdata, 32'h1);
    idle(3'd6, 8);
    wr(3'd4, 32'd1);
    idle(3'd6, 6);
    wr(3'd4, 32'd0);

    // PWM dimming
    wr(3'd0, 32'h01);
    wr(3'd3, 32'h00);
    wr(3'd5, 32'h40);
`ifdef SOPC_LEDS_PWM_EN
    idle(3'd5, 3);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(3'd5, 1);
      if (out_port[0]) cnt++;
    end
    check_eq("pwm_on_cycles", cnt, 64);
    wr(3'd5, 32'h00);
    idle(3'd5, 300);
    check_eq("pwm_zero_out", 32'(out_port), 32'h0);
    wr(3'd5, 32'hFF);
`else
    idle(3'd5, 1);
    check_eq("duty_absent_rd", readdata, 32'h0);
`endif
    idle(3'd0, 2);

    // Ignored writes and mid-blink reset
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h55);
    idle(3'd0, 1);
    check_eq("cs0_nowrite", readdata, 32'h01);
    wr(3'd7, 32'hFFFF_FFFF);
    idle(3'd7, 1);
    check_eq("addr7_rd", readdata, 32'h0);
    wr(3'd0, 32'hFF);
    wr(3'd3, 32'hFF);
    wr(3'd4, 32'd3);
    idle(3'd6, 4);
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 32'h1);
    check_eq("midreset_out", 32'(out_port), 32'(ResetValue));
    check_eq("midreset_status", readdata, 32'h1);
    idle(3'd3, 1);
    check_eq("midreset_mask", readdata, 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 4) != 0);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom();
      if (a == 3'd4 && $urandom_range(0, 9) != 0) wd = $urandom_range(0, 6);
      cycle(r, cs, wn, a, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
